// File: rtl/av_st_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// av_st_pkt_arbiter
//
// Packet-aware 2:1 Avalon-ST arbiter with one registered output stage.
// Two packet sources share one downstream sink. Grants are round-robin and
// change only at packet boundaries. Once a port wins an SOP beat, it keeps
// the grant until its EOP beat is accepted. Non-SOP beats that arrive while
// no port is locked are orphans: they are accepted and discarded.
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   inN_valid / inN_ready : sink handshake for source N (N = 0, 1)
//   inN_data, inN_channel, inN_empty,
//   inN_startofpacket, inN_endofpacket, inN_error : beat payload and framing
//   out_valid / out_ready : source handshake towards the downstream sink
//   out_data .. out_error : registered output beat
//
// Optional feature (macro AV_ST_PKT_ARBITER_STATS_EN):
//   pkt_count0/1 [31:0] : EOP beats transferred from port 0/1
//   drop_count   [15:0] : cycles in which at least one orphan was dropped
// ---------------------------------------------------------------------------
module av_st_pkt_arbiter #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int CHAN_WIDTH       = 1,
  parameter int DATA_WIDTH       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int EMPTY_WIDTH      = $clog2(SYMBOLS_PER_BEAT)
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   in0_valid,
  output logic                   in0_ready,
  input  logic [DATA_WIDTH-1:0]  in0_data,
  input  logic [CHAN_WIDTH-1:0]  in0_channel,
  input  logic [EMPTY_WIDTH-1:0] in0_empty,
  input  logic                   in0_startofpacket,
  input  logic                   in0_endofpacket,
  input  logic                   in0_error,

  input  logic                   in1_valid,
  output logic                   in1_ready,
  input  logic [DATA_WIDTH-1:0]  in1_data,
  input  logic [CHAN_WIDTH-1:0]  in1_channel,
  input  logic [EMPTY_WIDTH-1:0] in1_empty,
  input  logic                   in1_startofpacket,
  input  logic                   in1_endofpacket,
  input  logic                   in1_error,

  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CHAN_WIDTH-1:0]  out_channel,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic                   out_error
`ifdef AV_ST_PKT_ARBITER_STATS_EN
  ,
  output logic [31:0]            pkt_count0,
  output logic [31:0]            pkt_count1,
  output logic [15:0]            drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;   // port that won the most recent IDLE arbitration

  logic pipe_ready;
  logic req0, req1, orph0, orph1;
  logic win;            // IDLE winner; only meaningful when req0 | req1
  logic sel;            // port whose beat would be loaded this cycle
  logic load;           // selected beat transfers into the output register
  logic drop;           // at least one orphan is discarded this cycle

  logic [DATA_WIDTH-1:0]  sel_data;
  logic [CHAN_WIDTH-1:0]  sel_channel;
  logic [EMPTY_WIDTH-1:0] sel_empty;
  logic                   sel_sop, sel_eop, sel_error;

  // The output register can take a beat when it is empty or draining.
  assign pipe_ready = out_ready | ~out_valid;

  assign req0  = in0_valid &  in0_startofpacket;
  assign req1  = in1_valid &  in1_startofpacket;
  assign orph0 = in0_valid & ~in0_startofpacket;
  assign orph1 = in1_valid & ~in1_startofpacket;

  // On a tie the port that did not win last time goes first.
  assign win = (req0 & req1) ? ~last_grant : req1;

  // Selection is kept out of the main decode so the EOP of the selected beat
  // can steer the next state without a combinational loop.
  assign sel = (state == LOCK1) | ((state == IDLE) & win);

  assign sel_data    = sel ? in1_data          : in0_data;
  assign sel_channel = sel ? in1_channel       : in0_channel;
  assign sel_empty   = sel ? in1_empty         : in0_empty;
  assign sel_sop     = sel ? in1_startofpacket : in0_startofpacket;
  assign sel_eop     = sel ? in1_endofpacket   : in0_endofpacket;
  assign sel_error   = sel ? in1_error         : in0_error;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next = state;
    in0_ready  = 1'b0;
    in1_ready  = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;

    case (state)
      IDLE: begin
        // Orphans are swallowed regardless of downstream backpressure.
        if (orph0)              in0_ready = 1'b1;
        else if (req0 && !win)  in0_ready = pipe_ready;
        if (orph1)              in1_ready = 1'b1;
        else if (req1 && win)   in1_ready = pipe_ready;

        load = (req0 | req1) & pipe_ready;
        drop = orph0 | orph1;
        if (load && !sel_eop) state_next = win ? LOCK1 : LOCK0;
      end
      LOCK0: begin
        in0_ready = pipe_ready;
        load      = in0_valid & pipe_ready;
        if (load && sel_eop) state_next = IDLE;
      end
      LOCK1: begin
        in1_ready = pipe_ready;
        load      = in1_valid & pipe_ready;
        if (load && sel_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Nothing is accepted upstream while reset is asserted.
    if (reset) begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      load      = 1'b0;
      drop      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_empty         <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        out_valid         <= 1'b1;
        out_data          <= sel_data;
        out_channel       <= sel_channel;
        out_empty         <= sel_empty;
        out_startofpacket <= sel_sop;
        out_endofpacket   <= sel_eop;
        out_error         <= sel_error;
        if (state == IDLE) last_grant <= sel;
      end else if (out_ready) begin
        // Payload fields are left as-is; only valid drops.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AV_ST_PKT_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count0 <= '0;
      pkt_count1 <= '0;
      drop_count <= '0;
    end else begin
      if (load && sel_eop && !sel) pkt_count0 <= pkt_count0 + 32'd1;
      if (load && sel_eop &&  sel) pkt_count1 <= pkt_count1 + 32'd1;
      if (drop)                    drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_av_st_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_av_st_pkt_arbiter
//
// Self-checking bench for av_st_pkt_arbiter (default parameters). Expected
// output beats are pushed to a queue when stimulus is driven and compared in
// order by a monitor whenever the DUT transfers a beat downstream. A table of
// single-cycle vectors exercises IDLE arbitration and orphan dropping; short
// hand-written sequences cover locking, backpressure and reset mid-packet.
// Define AV_ST_PKT_ARBITER_STATS_EN for both files to also check counters.
// ---------------------------------------------------------------------------
module tb_av_st_pkt_arbiter;

  localparam int DW = 32;
  localparam int CW = 1;
  localparam int EW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] chan;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
    logic          err;
  } beat_t;

  typedef struct {
    logic v0, s0, v1, s1;   // inputs: valid / SOP per port (all beats EOP)
    logic r0, r1;           // expected readies
    int   fwd;              // expected forwarded port, 2 = none
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic          in0_valid, in0_ready, in0_sop, in0_eop, in0_err;
  logic [DW-1:0] in0_data;
  logic [CW-1:0] in0_channel;
  logic [EW-1:0] in0_empty;
  logic          in1_valid, in1_ready, in1_sop, in1_eop, in1_err;
  logic [DW-1:0] in1_data;
  logic [CW-1:0] in1_channel;
  logic [EW-1:0] in1_empty;

  logic          out_valid, out_ready, out_sop, out_eop, out_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_channel;
  logic [EW-1:0] out_empty;
`ifdef AV_ST_PKT_ARBITER_STATS_EN
  logic [31:0]   pkt_count0, pkt_count1;
  logic [15:0]   drop_count;
`endif

  beat_t out_beat;
  assign out_beat = {out_data, out_channel, out_empty, out_sop, out_eop, out_err};

  av_st_pkt_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .in0_valid         (in0_valid),
    .in0_ready         (in0_ready),
    .in0_data          (in0_data),
    .in0_channel       (in0_channel),
    .in0_empty         (in0_empty),
    .in0_startofpacket (in0_sop),
    .in0_endofpacket   (in0_eop),
    .in0_error         (in0_err),
    .in1_valid         (in1_valid),
    .in1_ready         (in1_ready),
    .in1_data          (in1_data),
    .in1_channel       (in1_channel),
    .in1_empty         (in1_empty),
    .in1_startofpacket (in1_sop),
    .in1_endofpacket   (in1_eop),
    .in1_error         (in1_err),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_empty         (out_empty),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_error         (out_err)
`ifdef AV_ST_PKT_ARBITER_STATS_EN
    ,
    .pkt_count0        (pkt_count0),
    .pkt_count1        (pkt_count1),
    .drop_count        (drop_count)
`endif
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic sop, input logic eop,
                               input logic [CW-1:0] ch, input logic err);
    beat_t b;
    b.data  = d;
    b.chan  = ch;
    b.empty = d[EW-1:0];
    b.sop   = sop;
    b.eop   = eop;
    b.err   = err;
    return b;
  endfunction

  task automatic drive(input int port, input logic v, input beat_t b);
    if (port == 0) begin
      in0_valid = v; in0_data = b.data; in0_channel = b.chan; in0_empty = b.empty;
      in0_sop = b.sop; in0_eop = b.eop; in0_err = b.err;
    end else begin
      in1_valid = v; in1_data = b.data; in1_channel = b.chan; in1_empty = b.empty;
      in1_sop = b.sop; in1_eop = b.eop; in1_err = b.err;
    end
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset for one edge with an orphan presented on in0, which must not
  // be accepted while reset is high.
  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b1, mk(32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    check("reset_in0_ready", in0_ready, 1'b0);
    check("reset_in1_ready", in1_ready, 1'b0);
    tick();
    check("reset_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    tick();
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a beat transfers at the coming edge when valid and
  // ready are both high; sample them on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_qsize", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", out_beat, e);
      end
    end
  end

  vec_t  vec[10];
  beat_t b0, b1;
  int    acc;

  initial begin
    // {v0, s0, v1, s1, r0, r1, fwd}; all beats carry EOP so state stays IDLE.
    vec[0] = '{1, 1, 1, 1, 1, 0, 0};  // tie after reset: port 0
    vec[1] = '{1, 1, 1, 1, 0, 1, 1};  // tie: alternates to port 1
    vec[2] = '{1, 1, 1, 1, 1, 0, 0};  // tie: back to port 0
    vec[3] = '{1, 1, 0, 0, 1, 0, 0};  // single requester 0
    vec[4] = '{1, 1, 1, 0, 1, 1, 0};  // request 0 plus orphan 1 dropped
    vec[5] = '{1, 0, 1, 0, 1, 1, 2};  // both orphans dropped
    vec[6] = '{0, 0, 1, 1, 0, 1, 1};  // single requester 1
    vec[7] = '{1, 0, 1, 1, 1, 1, 1};  // orphan 0 dropped, request 1
    vec[8] = '{0, 0, 0, 0, 0, 0, 2};  // nothing valid
    vec[9] = '{1, 1, 1, 1, 1, 0, 0};  // tie after port 1 won: port 0

    reset     = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("por_out_beat_zero", out_beat, '0);
    check("por_out_valid", out_valid, 1'b0);
    reset = 1'b0;

    // ---- table: IDLE arbitration and orphan handling ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b0 = mk(32'hA000_0000 + i * 17, vec[i].s0, 1'b1, 1'b0, i[0]);
      b1 = mk(32'hB000_0000 + i * 29, vec[i].s1, 1'b1, 1'b1, i[1]);
      drive(0, vec[i].v0, b0);
      drive(1, vec[i].v1, b1);
      if (vec[i].fwd == 0)      exp_q.push_back(b0);
      else if (vec[i].fwd == 1) exp_q.push_back(b1);
      #1;
      check($sformatf("tbl%0d_in0_ready", i), in0_ready, vec[i].r0);
      check($sformatf("tbl%0d_in1_ready", i), in1_ready, vec[i].r1);
      tick();
    end
    drain();

    // ---- single port, 3-beat packet ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b0 = mk(32'h1111_0000 + i, i == 0, i == 2, 1'b0, 1'b0);
      drive(0, 1'b1, b0);
      exp_q.push_back(b0);
      #1;
      check("single_in0_ready", in0_ready, 1'b1);
      check("single_in1_ready", in1_ready, 1'b0);
      tick();
      check("single_out_valid", out_valid, 1'b1);
    end
    idle_inputs();
    tick();
    check("single_out_valid_after", out_valid, 1'b0);
`ifdef AV_ST_PKT_ARBITER_STATS_EN
    check("single_pkt_count0", pkt_count0, 32'd1);
`endif
    drain();

    // ---- tie: two 2-beat packets, four back-to-back output beats ----
    do_reset();
    b0 = mk(32'h2222_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    b1 = mk(32'h3333_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, b0);
    drive(1, 1'b1, b1);
    exp_q.push_back(b0);
    #1;
    check("tie_c1_in0_ready", in0_ready, 1'b1);
    check("tie_c1_in1_ready", in1_ready, 1'b0);
    tick();
    b0 = mk(32'h2222_0001, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b1, b0);
    exp_q.push_back(b0);
    #1;
    check("tie_c2_in1_ready", in1_ready, 1'b0);
    check("tie_c2_out_valid", out_valid, 1'b1);
    tick();
    drive(0, 1'b0, '0);
    exp_q.push_back(b1);
    #1;
    check("tie_c3_in1_ready", in1_ready, 1'b1);
    check("tie_c3_out_valid", out_valid, 1'b1);
    tick();
    b1 = mk(32'h3333_0001, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b1, b1);
    exp_q.push_back(b1);
    #1;
    check("tie_c4_in1_ready", in1_ready, 1'b1);
    check("tie_c4_out_valid", out_valid, 1'b1);
    tick();
    idle_inputs();
    check("tie_c5_out_valid", out_valid, 1'b1);
    drain();

    // ---- lock: in1 SOP held off while port 0 is locked ----
    do_reset();
    b0 = mk(32'h4444_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, b0);
    exp_q.push_back(b0);
    tick();
    b0 = mk(32'h4444_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    b1 = mk(32'h5555_0000, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, b0);
    drive(1, 1'b1, b1);
    exp_q.push_back(b0);
    #1;
    check("lock_c2_in1_ready", in1_ready, 1'b0);
    tick();
    b0 = mk(32'h4444_0002, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, b0);
    exp_q.push_back(b0);
    #1;
    check("lock_c3_in1_ready", in1_ready, 1'b0);
    tick();
    drive(0, 1'b0, '0);
    exp_q.push_back(b1);
    #1;
    check("lock_c4_in1_ready", in1_ready, 1'b1);
    check("lock_c4_out_valid", out_valid, 1'b1);
    tick();
    idle_inputs();
    check("lock_c5_out_valid", out_valid, 1'b1);
    drain();

    // ---- backpressure: out_ready low for three cycles mid-packet ----
    do_reset();
    acc = 0;
    b0 = mk(32'h6666_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, b0);
    exp_q.push_back(b0);
    tick();
    drive(0, 1'b0, '0);          // upstream gap lets the register drain
    tick();
    b0 = mk(32'h6666_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    b1 = mk(32'h6666_0002, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b0;
      drive(0, 1'b1, (c == 0) ? b0 : b1);
      if (c == 0) exp_q.push_back(b0);
      #1;
      if (in0_valid && in0_ready) acc++;
      if (c > 0) begin
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_out_beat_hold", out_beat, b0);
      end
      tick();
    end
    check("bp_accepted_during_stall", acc, 1);
    out_ready = 1'b1;
    exp_q.push_back(b1);
    #1;
    check("bp_resume_in0_ready", in0_ready, 1'b1);
    tick();
    drain();

    // ---- orphan in IDLE ----
    do_reset();
`ifdef AV_ST_PKT_ARBITER_STATS_EN
    check("orphan_drop_count_before", drop_count, 16'd0);
`endif
    drive(1, 1'b1, mk(32'h7777_0000, 1'b0, 1'b0, 1'b1, 1'b0));
    #1;
    check("orphan_in1_ready", in1_ready, 1'b1);
    check("orphan_in0_ready", in0_ready, 1'b0);
    tick();
    idle_inputs();
    check("orphan_out_valid", out_valid, 1'b0);
`ifdef AV_ST_PKT_ARBITER_STATS_EN
    check("orphan_drop_count_after", drop_count, 16'd1);
`endif
    drain();

    // ---- reset after beat 2 of a 4-beat packet ----
    do_reset();
    b0 = mk(32'h8888_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, b0);
    exp_q.push_back(b0);
    tick();
    b0 = mk(32'h8888_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, b0);
    exp_q.push_back(b0);
    tick();
    reset = 1'b1;
    drive(0, 1'b1, mk(32'h8888_0002, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    check("rst_mid_in0_ready", in0_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_orphan2_ready", in0_ready, 1'b1);
    tick();
    drive(0, 1'b1, mk(32'h8888_0003, 1'b0, 1'b1, 1'b0, 1'b0));
    #1;
    check("rst_mid_orphan3_ready", in0_ready, 1'b1);
    check("rst_mid_out_valid2", out_valid, 1'b0);
    tick();
    idle_inputs();
    check("rst_mid_out_valid3", out_valid, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
